// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared defaults and arbiter state type for the round-robin bus
package bus_pkg;

    localparam int NM_DEF    = 4;
    localparam int NS_DEF    = 4;
    localparam int AW_DEF    = 8;
    localparam int DW_DEF    = 32;
    localparam int RGN_W_DEF = 5;

    typedef enum logic {
        PARK = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

endpackage

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - non-preemptive round-robin arbiter with parked owner
module bus_rr_arbiter import bus_pkg::*; #(
    parameter int NM = NM_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NM-1:0] req,
    output logic [NM-1:0] grant
);

    localparam int OW = $clog2(NM);

    bus_state_t    state;
    bus_state_t    state_nx;
    logic [OW-1:0] owner;
    logic [OW-1:0] owner_nx;
    logic [OW-1:0] rr_owner;
    logic          rr_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PARK;
            owner <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end

    // First requester after the owner, wrapping; the owner itself is handled by the FSM.
    always_comb begin
        rr_owner = owner;
        rr_found = 1'b0;
        for (int k = 1; k < NM; k++) begin
            if (!rr_found && req[(int'(owner) + k) % NM]) begin
                rr_found = 1'b1;
                rr_owner = OW'((int'(owner) + k) % NM);
            end
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        case (state)
            PARK: begin
                if (|req) begin
                    state_nx = BUSY;
                    if (!req[owner]) begin
                        owner_nx = rr_owner;
                    end
                end
            end
            BUSY: begin
                if (!req[owner]) begin
                    if (rr_found) begin
                        owner_nx = rr_owner;
                    end else begin
                        state_nx = PARK;
                    end
                end
            end
            default: begin
                state_nx = PARK;
                owner_nx = '0;
            end
        endcase
    end

    // Grant is a pure decode of the owner register, so it only changes on a clock edge.
    always_comb begin
        grant        = '0;
        grant[owner] = 1'b1;
    end

endmodule

// File: rtl/bus_rr.sv
// rtl/bus_rr.sv - shared bus with round-robin arbitration, region decode and registered read return
module bus_rr import bus_pkg::*; #(
    parameter int NM    = NM_DEF,
    parameter int NS    = NS_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int RGN_W = RGN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NM-1:0]    M_req,
    input  logic [NM-1:0]    M_wr,
    input  logic [NM*AW-1:0] M_address,
    input  logic [NM*DW-1:0] M_dout,
    input  logic [NS*DW-1:0] S_dout,
    output logic [NM-1:0]    M_grant,
    output logic [DW-1:0]    M_din,
    output logic [NS-1:0]    S_sel,
    output logic [AW-1:0]    S_address,
    output logic             S_wr,
    output logic [DW-1:0]    S_din,
    output logic             dec_err
);

    localparam int OW = $clog2(NM);

    logic [OW-1:0]       owner;
    logic [OW-1:0]       mux_idx;
    logic                owner_req;
    logic [AW-RGN_W-1:0] region;
    logic                hit;
    logic [NS-1:0]       sel_q;

    bus_rr_arbiter #(
        .NM(NM)
    ) u_arbiter (
        .clk  (clk),
        .reset(reset),
        .req  (M_req),
        .grant(M_grant)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < NM; i++) begin
            if (M_grant[i]) begin
                owner = OW'(i);
            end
        end
    end

    // While in reset the address phase shows master 0 with its request masked off.
    assign mux_idx   = reset ? '0 : owner;
    assign owner_req = !reset && M_req[mux_idx];

    assign S_address = M_address[mux_idx*AW +: AW];
    assign S_din     = M_dout[mux_idx*DW +: DW];
    assign S_wr      = owner_req && M_wr[mux_idx];

    assign region  = S_address[AW-1:RGN_W];
    assign hit     = int'(region) < NS;
    assign dec_err = owner_req && !hit;

    always_comb begin
        S_sel = '0;
        for (int j = 0; j < NS; j++) begin
            S_sel[j] = owner_req && (int'(region) == j);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= '0;
        end else begin
            sel_q <= S_sel;
        end
    end

    always_comb begin
        M_din = '0;
        for (int j = 0; j < NS; j++) begin
            if (sel_q[j]) begin
                M_din = M_din | S_dout[j*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_bus_rr.sv
// tb/tb_bus_rr.sv - randomized and directed self-checking bench for bus_rr
module tb_bus_rr;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   M_req;
    logic [3:0]   M_wr;
    logic [31:0]  M_address;
    logic [127:0] M_dout;
    logic [127:0] S_dout;
    logic [3:0]   M_grant;
    logic [31:0]  M_din;
    logic [3:0]   S_sel;
    logic [7:0]   S_address;
    logic         S_wr;
    logic [31:0]  S_din;
    logic         dec_err;

    int n_tests = 0;
    int n_fail  = 0;

    int m_owner = 0;
    bit m_busy  = 1'b0;
    int m_prev  = -1;

    bus_rr dut (
        .clk      (clk),
        .reset    (reset),
        .M_req    (M_req),
        .M_wr     (M_wr),
        .M_address(M_address),
        .M_dout   (M_dout),
        .S_dout   (S_dout),
        .M_grant  (M_grant),
        .M_din    (M_din),
        .S_sel    (S_sel),
        .S_address(S_address),
        .S_wr     (S_wr),
        .S_din    (S_din),
        .dec_err  (dec_err)
    );

    always #5 clk = ~clk;

    function automatic int next_rr(int own, logic [3:0] rq);
        for (int d = 1; d < 4; d++) begin
            if (rq[(own + d) % 4]) return (own + d) % 4;
        end
        return -1;
    endfunction

    // Expected address-phase view: which slave (or -1), decode error, write strobe.
    function automatic void exp_comb(output int sel, output bit err, output bit wr,
                                     output logic [7:0] addr, output logic [31:0] din);
        int  idx;
        bit  rq;
        int  rgn;
        idx  = reset ? 0 : m_owner;
        rq   = !reset && M_req[idx];
        addr = M_address[idx*8 +: 8];
        din  = M_dout[idx*32 +: 32];
        rgn  = int'(addr) / 32;
        sel  = (rq && rgn < 4) ? rgn : -1;
        err  = rq && rgn >= 4;
        wr   = rq && M_wr[idx];
    endfunction

    task automatic tick();
        int          sel;
        bit          err;
        bit          wr;
        logic [7:0]  a;
        logic [31:0] d;
        int          n;
        @(posedge clk);
        exp_comb(sel, err, wr, a, d);
        if (reset) begin
            m_owner = 0;
            m_busy  = 1'b0;
            m_prev  = -1;
        end else begin
            m_prev = sel;
            n = next_rr(m_owner, M_req);
            if (m_busy) begin
                if (!M_req[m_owner]) begin
                    if (n >= 0) m_owner = n;
                    else m_busy = 1'b0;
                end
            end else if (M_req != 4'b0) begin
                m_busy = 1'b1;
                if (!M_req[m_owner]) m_owner = n;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        M_req     = '0;
        M_wr      = '0;
        M_address = '0;
        M_dout    = '0;
        S_dout    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        M_req = 4'b1001;
        M_wr  = 4'b1001;
        M_address[7:0]   = 8'hA0;
        M_address[31:24] = 8'h30;
        @(negedge clk);
        n_tests++;
        if (S_sel !== 4'b0 || S_wr !== 1'b0 || dec_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_comb: S_sel=%b S_wr=%b dec_err=%b, required 0000/0/0", S_sel, S_wr, dec_err);
        end
        tick();
        tick();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        n_tests++;
        if (M_grant !== 4'b0001 || S_sel !== 4'b0 || M_din !== 32'h0 || dec_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: grant=%b S_sel=%b M_din=%h dec_err=%b, required 0001/0000/0/0",
                     M_grant, S_sel, M_din, dec_err);
        end
        tick();
    endtask

    task automatic test_write_sweep();
        logic [7:0]  addrs[5]  = '{8'h01, 8'h21, 8'h41, 8'h61, 8'hA0};
        logic [3:0]  sels[5]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        bit          errs[5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d              = $urandom;
            M_req          = 4'b0001;
            M_wr           = 4'b0001;
            M_address[7:0] = addrs[i];
            M_dout[31:0]   = d;
            @(negedge clk);
            n_tests++;
            if (S_sel !== sels[i] || dec_err !== errs[i] || S_din !== d || S_wr !== 1'b1) begin
                n_fail++;
                $display("FAIL write_sweep[%0h]: S_sel=%b dec_err=%b S_din=%h S_wr=%b, required %b/%b/%h/1",
                         addrs[i], S_sel, dec_err, S_din, S_wr, sels[i], errs[i], d);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_read();
        do_reset();
        for (int j = 0; j < 4; j++) S_dout[j*32 +: 32] = 32'(j + 1);
        M_req          = 4'b0001;
        M_address[7:0] = 8'h25;
        @(negedge clk);
        tick();
        M_address[7:0] = 8'h65;
        @(negedge clk);
        n_tests++;
        if (M_din !== 32'd2) begin
            n_fail++;
            $display("FAIL read_first: M_din=%0d, required 2", M_din);
        end
        tick();
        M_req = 4'b0000;
        @(negedge clk);
        n_tests++;
        if (M_din !== 32'd4) begin
            n_fail++;
            $display("FAIL read_second: M_din=%0d, required 4", M_din);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (M_din !== 32'd0) begin
            n_fail++;
            $display("FAIL read_idle: M_din=%0d, required 0", M_din);
        end
        clear_inputs();
    endtask

    task automatic test_rotation();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int order[$];
        int cur;
        int cnt;
        int g;
        do_reset();
        cur = -1;
        cnt = 0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            g = -1;
            for (int b = 0; b < 4; b++) if (M_grant == 4'(1 << b)) g = b;
            if (g != cur) begin
                order.push_back(g);
                cur = g;
                cnt = 0;
            end
            cnt++;
            M_req = 4'hF;
            if (cnt == 4 && g >= 0) M_req[g] = 1'b0;
            tick();
        end
        n_tests++;
        if (order.size() != 5) begin
            n_fail++;
            $display("FAIL rotation_len: saw %0d grant changes in 40 cycles, required 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (order[i] != exp_order[i]) begin
                    n_fail++;
                    $display("FAIL rotation[%0d]: owner=%0d, required %0d", i, order[i], exp_order[i]);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_skip();
        do_reset();
        M_req = 4'b0100;
        tick();
        tick();
        M_req = 4'b0010;
        @(negedge clk);
        n_tests++;
        if (M_grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL skip_owner: grant=%b, required 0100", M_grant);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (M_grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL skip_next: grant=%b, required 0010", M_grant);
        end
        clear_inputs();
    endtask

    task automatic test_reset_midwrite();
        do_reset();
        M_req             = 4'b1000;
        M_wr              = 4'b1000;
        M_address[31:24]  = 8'h30;
        M_dout[127:96]    = 32'hCAFE_0003;
        S_dout            = {4{32'h5A5A_5A5A}};
        tick();
        @(negedge clk);
        n_tests++;
        if (M_grant !== 4'b1000 || S_sel !== 4'b0010 || S_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL midwrite_setup: grant=%b S_sel=%b S_wr=%b, required 1000/0010/1", M_grant, S_sel, S_wr);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (S_sel !== 4'b0 || S_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL midwrite_in_reset: S_sel=%b S_wr=%b, required 0000/0", S_sel, S_wr);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (M_grant !== 4'b0001 || S_sel !== 4'b0 || S_wr !== 1'b0 || M_din !== 32'h0) begin
            n_fail++;
            $display("FAIL midwrite_after: grant=%b S_sel=%b S_wr=%b M_din=%h, required 0001/0000/0/0",
                     M_grant, S_sel, S_wr, M_din);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (M_din !== 32'h0) begin
            n_fail++;
            $display("FAIL midwrite_din: M_din=%h, required 0", M_din);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int          sel;
        bit          err;
        bit          wr;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  e_sel;
        logic [31:0] e_din;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 49) == 0);
            M_req     = 4'($urandom_range(0, 15));
            M_wr      = 4'($urandom_range(0, 15));
            M_address = $urandom;
            M_dout    = {$urandom, $urandom, $urandom, $urandom};
            S_dout    = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            exp_comb(sel, err, wr, a, d);
            e_sel = (sel < 0) ? 4'b0 : 4'(1 << sel);
            e_din = (m_prev < 0) ? 32'h0 : S_dout[m_prev*32 +: 32];
            n_tests++;
            if (M_grant !== 4'(1 << m_owner) || S_sel !== e_sel || dec_err !== err || S_wr !== wr
                || S_address !== a || S_din !== d || M_din !== e_din) begin
                n_fail++;
                $display("FAIL random[%0d]: grant=%b sel=%b err=%b wr=%b addr=%h din=%h mdin=%h, required %b/%b/%b/%b/%h/%h/%h",
                         c, M_grant, S_sel, dec_err, S_wr, S_address, S_din, M_din,
                         4'(1 << m_owner), e_sel, err, wr, a, d, e_din);
            end
            tick();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        test_reset();
        test_write_sweep();
        test_read();
        test_rotation();
        test_skip();
        test_reset_midwrite();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_rr.md
BUS_RR -- requirements
Module: bus_rr

Interface
REQ-001 SHALL have parameter NM, default 4: number of masters, 2..8.
REQ-002 SHALL have parameter NS, default 4: number of slaves, 1..8, with NS*2^RGN_W <= 2^AW.
REQ-003 SHALL have parameter AW, default 8: address width.
REQ-004 SHALL have parameter DW, default 32: data width.
REQ-005 SHALL have parameter RGN_W, default 5: log2 of each slave's address region size in words.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port M_req, input, NM bits: per-master bus request.
REQ-009 SHALL have port M_wr, input, NM bits: per-master write enable (1 = write, 0 = read).
REQ-010 SHALL have port M_address, input, NM*AW bits: master i's address at bits [i*AW +: AW].
REQ-011 SHALL have port M_dout, input, NM*DW bits: master i's write data at bits [i*DW +: DW].
REQ-012 SHALL have port S_dout, input, NS*DW bits: slave j's read data at bits [j*DW +: DW].
REQ-013 SHALL have port M_grant, output, NM bits: one-hot grant, registered.
REQ-014 SHALL have port M_din, output, DW bits: read data returned to the masters.
REQ-015 SHALL have port S_sel, output, NS bits: one-hot or all-zero slave select.
REQ-016 SHALL have port S_address, output, AW bits: address forwarded to the slaves.
REQ-017 SHALL have port S_wr, output, 1 bit: write strobe to the slaves.
REQ-018 SHALL have port S_din, output, DW bits: write data to the slaves.
REQ-019 SHALL have port dec_err, output, 1 bit: the owner's access hits no slave region.

Function
REQ-020 Arbiter SHALL be a two-state FSM: PARK (no active owner) and BUSY (owner holding the bus).
- Exactly one M_grant bit SHALL be high at all times.
- The granted index is called "owner".
REQ-021 In BUSY, while M_req[owner]=1, the grant SHALL be held with no preemption, however long the request lasts.
REQ-022 When M_req[owner]=0 at an edge, the next grant SHALL go to the first requesting master found searching owner+1, owner+2, ... cyclically mod NM.
- BUSY->BUSY if such a master exists.
- BUSY->PARK, grant staying on owner, otherwise.
REQ-023 In PARK, when any M_req is high at an edge:
- M_req[owner]=1 SHALL keep the grant on owner.
- Otherwise the round-robin search of REQ-022 SHALL select the new owner.
- The FSM SHALL enter BUSY.
REQ-024 Grant latency SHALL be one cycle: a request sampled at edge k shows M_grant at edge k+1 at the earliest.
REQ-025 S_address, S_din and S_wr SHALL be combinational muxes of the owner's address, data and write bits.
- S_wr SHALL be M_wr[owner] & M_req[owner].
REQ-026 Decode: the region index r = M_address[owner][AW-1:RGN_W].
- If M_req[owner]=1 and r<NS, S_sel[r] SHALL be 1.
- Otherwise S_sel SHALL be all-zero.
- dec_err SHALL be M_req[owner] & (r>=NS).
REQ-027 A write with dec_err=1 SHALL be dropped: S_sel=0, no slave is written.
REQ-028 Read path: the S_sel value SHALL be registered each edge.
- M_din SHALL be S_dout of the slave selected in the previous cycle, giving one-cycle read latency.
- M_din SHALL be 0 if no slave was selected.
REQ-029 A request and a release in the same cycle SHALL be arbitrated per REQ-022 using only that cycle's M_req.
REQ-030 If the owner drops its request at a region boundary, the address-phase outputs SHALL follow REQ-026 in that same cycle.

Reset
REQ-031 On reset=1 at an edge:
- FSM SHALL go to PARK.
- M_grant SHALL be 1 on bit 0 only.
- The registered S_sel SHALL clear, so M_din=0 the next cycle.
REQ-032 Reset asserted mid-transfer SHALL abort it, with no further slave select beyond the reset cycle.
REQ-033 During reset, the combinational outputs SHALL reflect master 0 with M_req forced to 0: S_sel=0, S_wr=0, dec_err=0.

Structure
REQ-034 A shared package bus_pkg SHALL hold:
- the default values of NM, NS, AW, DW and RGN_W;
- the FSM state enum {PARK, BUSY}.
REQ-035 The round-robin arbiter SHALL be the sub-module bus_rr_arbiter (ports clk, reset, req, grant), containing the FSM and the owner register.
- Decode and muxing SHALL stay in bus_rr.

Verification (NM=4, NS=4, AW=8, DW=32, RGN_W=5)
REQ-036 Reset, then no requests: M_grant=4'b0001, S_sel=0, M_din=0, dec_err=0.
REQ-037 M0 write sweep, M0_req=1, M0_wr=1, addresses 0x01, 0x21, 0x41, 0x61, 0xA0:
- S_sel SHALL be 0001, 0010, 0100, 1000, 0000.
- dec_err SHALL be 1 only at 0xA0.
- S_din SHALL equal M0_dout each cycle.
REQ-038 Read with S_dout = 1, 2, 3, 4 for slaves 0..3, M0 reading 0x25 then 0x65: M_din SHALL be 2 one cycle later, then 4.
REQ-039 All four masters request continuously, each owner dropping req for one cycle after 3 grant cycles: grant order SHALL be M0, M1, M2, M3, M0.
REQ-040 M2 owns the bus and drops req while only M1 requests: grant SHALL move to M1 next edge, skipping M3 and M0.
REQ-041 reset=1 mid-write at address 0x30 by M3: on the next edge M_grant=0001, S_sel=0, S_wr=0, and M_din=0 afterwards.
